// File: rtl/decoder_pkg.sv
// Shared definitions for the RV32I decoder: opcode constants, the encodings
// of the ALU, immediate-format and memory-size control codes, and a helper
// that maps funct3 onto an ALU operation.
package decoder_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_SHIFT = 3'b110,
        ALU_NONE  = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        SX_I     = 3'b000,
        SX_S     = 3'b001,
        SX_B     = 3'b010,
        SX_U     = 3'b011,
        SX_J     = 3'b100,
        SX_SHAMT = 3'b101,
        SX_NONE  = 3'b111
    } sx_op_e;

    typedef enum logic [2:0] {
        MEM_B    = 3'b000,
        MEM_W    = 3'b001,
        MEM_H    = 3'b010,
        MEM_BU   = 3'b011,
        MEM_HU   = 3'b100,
        MEM_NONE = 3'b111
    } sx_op2_e;

    // funct3 to ALU operation; isSub only matters for the add/sub slot,
    // and SLT/SLTU share one code since signedness travels in f3.
    function automatic alu_op_e aluFromF3(input logic [2:0] f3, input logic isSub);
        alu_op_e op;
        case (f3)
            3'b000:         op = isSub ? ALU_SUB : ALU_ADD;
            3'b001, 3'b101: op = ALU_SHIFT;
            3'b010, 3'b011: op = ALU_SLT;
            3'b100:         op = ALU_XOR;
            3'b110:         op = ALU_OR;
            default:        op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decoder_imm_unpack.sv
// Gathers the raw immediate bits of an instruction into a right-justified,
// zero-filled word according to the immediate format. No sign extension is
// done here; the consumer extends using the format code.
module decoder_imm_unpack
    import decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [2:0]            i_sxOp,
    output logic [DATA_WIDTH-1:0] o_unextData
);

    // Select the bit gather for the format; NONE and unused codes give zero.
    always_comb begin
        o_unextData = '0;
        case (i_sxOp)
            SX_I:     o_unextData[11:0] = i_instr[31:20];
            SX_S:     o_unextData[11:0] = {i_instr[31:25], i_instr[11:7]};
            SX_B:     o_unextData[12:0] = {i_instr[31], i_instr[7], i_instr[30:25],
                                           i_instr[11:8], 1'b0};
            SX_U:     o_unextData[19:0] = i_instr[31:12];
            SX_J:     o_unextData[20:0] = {i_instr[31], i_instr[19:12], i_instr[20],
                                           i_instr[30:21], 1'b0};
            SX_SHAMT: o_unextData[4:0]  = i_instr[24:20];
            default:  o_unextData       = '0;
        endcase
    end

endmodule

// File: rtl/decoder.sv
// RV32I instruction decoder. Splits the instruction into register indices,
// funct fields and raw immediate bits and produces ALU, immediate-format,
// memory-size and write-enable controls, all registered one cycle after the
// instruction is presented. Invalid words decode to the same response as reset.
// Optional build macro DECODER_ILLEGAL_EN adds a registered 'illegal' flag.
module decoder
    import decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int RW = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [2:0]            f3,
    output logic [6:0]            f7,
    output logic [2:0]            alu_op,
    output logic [2:0]            sx_op,
    output logic [2:0]            sx_op2,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic [RW-1:0]         rs1,
    output logic [RW-1:0]         rs2,
    output logic [RW-1:0]         rd,
    output logic [DATA_WIDTH-1:0] unextended_data
`ifdef DECODER_ILLEGAL_EN
    ,
    output logic                  illegal
`endif
);

    logic [6:0]            w_opcode;
    logic [2:0]            w_f3Field;
    logic [6:0]            w_f7Field;
    logic                  w_valid;
    alu_op_e               w_aluOp;
    sx_op_e                w_sxOp;
    sx_op2_e               w_sxOp2;
    logic                  w_memWrite;
    logic                  w_regWrite;
    logic                  w_memRead;
    logic                  w_useRs1;
    logic                  w_useRs2;
    logic                  w_useRd;
    logic                  w_useF3;
    logic                  w_useF7;
    logic [DATA_WIDTH-1:0] w_immData;

    logic [2:0]            r_f3;
    logic [6:0]            r_f7;
    logic [2:0]            r_aluOp;
    logic [2:0]            r_sxOp;
    logic [2:0]            r_sxOp2;
    logic                  r_memWrite;
    logic                  r_regWrite;
    logic                  r_memRead;
    logic [RW-1:0]         r_rs1;
    logic [RW-1:0]         r_rs2;
    logic [RW-1:0]         r_rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_illegal;

    assign w_opcode  = instruction[6:0];
    assign w_f3Field = instruction[14:12];
    assign w_f7Field = instruction[31:25];

    // Opcode decode; anything not recognised falls back to the NONE response.
    always_comb begin
        w_valid    = 1'b1;
        w_aluOp    = ALU_NONE;
        w_sxOp     = SX_NONE;
        w_sxOp2    = MEM_NONE;
        w_memWrite = 1'b0;
        w_regWrite = 1'b0;
        w_memRead  = 1'b0;
        w_useRs1   = 1'b0;
        w_useRs2   = 1'b0;
        w_useRd    = 1'b0;
        w_useF3    = 1'b0;
        w_useF7    = 1'b0;
        case (w_opcode)
            OPC_LOAD: begin
                w_aluOp    = ALU_ADD;
                w_sxOp     = SX_I;
                w_memRead  = 1'b1;
                w_regWrite = 1'b1;
                w_useRs1   = 1'b1;
                w_useRd    = 1'b1;
                w_useF3    = 1'b1;
                case (w_f3Field)
                    3'b000:  w_sxOp2 = MEM_B;
                    3'b001:  w_sxOp2 = MEM_H;
                    3'b010:  w_sxOp2 = MEM_W;
                    3'b100:  w_sxOp2 = MEM_BU;
                    3'b101:  w_sxOp2 = MEM_HU;
                    default: w_valid = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_aluOp    = ALU_ADD;
                w_sxOp     = SX_S;
                w_memWrite = 1'b1;
                w_useRs1   = 1'b1;
                w_useRs2   = 1'b1;
                w_useF3    = 1'b1;
                case (w_f3Field)
                    3'b000:  w_sxOp2 = MEM_B;
                    3'b001:  w_sxOp2 = MEM_H;
                    3'b010:  w_sxOp2 = MEM_W;
                    default: w_valid = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                w_aluOp    = aluFromF3(w_f3Field, 1'b0);
                w_regWrite = 1'b1;
                w_useRs1   = 1'b1;
                w_useRd    = 1'b1;
                w_useF3    = 1'b1;
                if (w_f3Field == 3'b001 || w_f3Field == 3'b101) begin
                    w_sxOp  = SX_SHAMT;
                    w_useF7 = 1'b1;
                end else begin
                    w_sxOp  = SX_I;
                end
            end
            OPC_OP: begin
                w_aluOp    = aluFromF3(w_f3Field, w_f7Field[5]);
                w_regWrite = 1'b1;
                w_useRs1   = 1'b1;
                w_useRs2   = 1'b1;
                w_useRd    = 1'b1;
                w_useF3    = 1'b1;
                w_useF7    = 1'b1;
            end
            OPC_BRANCH: begin
                w_aluOp  = ALU_SUB;
                w_sxOp   = SX_B;
                w_useRs1 = 1'b1;
                w_useRs2 = 1'b1;
                w_useF3  = 1'b1;
            end
            OPC_JAL: begin
                w_aluOp    = ALU_ADD;
                w_sxOp     = SX_J;
                w_regWrite = 1'b1;
                w_useRd    = 1'b1;
            end
            OPC_JALR: begin
                w_aluOp    = ALU_ADD;
                w_sxOp     = SX_I;
                w_regWrite = 1'b1;
                w_useRs1   = 1'b1;
                w_useRd    = 1'b1;
                w_useF3    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_aluOp    = ALU_ADD;
                w_sxOp     = SX_U;
                w_regWrite = 1'b1;
                w_useRd    = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase
        if (!w_valid) begin
            w_aluOp    = ALU_NONE;
            w_sxOp     = SX_NONE;
            w_sxOp2    = MEM_NONE;
            w_memWrite = 1'b0;
            w_regWrite = 1'b0;
            w_memRead  = 1'b0;
            w_useRs1   = 1'b0;
            w_useRs2   = 1'b0;
            w_useRd    = 1'b0;
            w_useF3    = 1'b0;
            w_useF7    = 1'b0;
        end
    end

    decoder_imm_unpack #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_immUnpack (
        .i_instr     (instruction),
        .i_sxOp      (w_sxOp),
        .o_unextData (w_immData)
    );

    // Output register; reset drives the same response as an invalid decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f3       <= '0;
            r_f7       <= '0;
            r_aluOp    <= ALU_NONE;
            r_sxOp     <= SX_NONE;
            r_sxOp2    <= MEM_NONE;
            r_memWrite <= 1'b0;
            r_regWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_data     <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_f3       <= w_useF3  ? w_f3Field : 3'b000;
            r_f7       <= w_useF7  ? w_f7Field : 7'b0000000;
            r_aluOp    <= w_aluOp;
            r_sxOp     <= w_sxOp;
            r_sxOp2    <= w_sxOp2;
            r_memWrite <= w_memWrite;
            r_regWrite <= w_regWrite;
            r_memRead  <= w_memRead;
            r_rs1      <= w_useRs1 ? instruction[15 +: RW] : '0;
            r_rs2      <= w_useRs2 ? instruction[20 +: RW] : '0;
            r_rd       <= w_useRd  ? instruction[7 +: RW]  : '0;
            r_data     <= w_immData;
            r_illegal  <= ~w_valid;
        end
    end

    assign f3              = r_f3;
    assign f7              = r_f7;
    assign alu_op          = r_aluOp;
    assign sx_op           = r_sxOp;
    assign sx_op2          = r_sxOp2;
    assign mem_write       = r_memWrite;
    assign reg_write       = r_regWrite;
    assign mem_read        = r_memRead;
    assign rs1             = r_rs1;
    assign rs2             = r_rs2;
    assign rd              = r_rd;
    assign unextended_data = r_data;

`ifdef DECODER_ILLEGAL_EN
    assign illegal = r_illegal;
`else
    logic w_unusedIllegal;
    assign w_unusedIllegal = r_illegal;
`endif

endmodule

// File: tb/tb_decoder.sv
// Directed testbench for the RV32I decoder. Each step drives one instruction
// on the falling edge and checks every output one time unit after the next
// rising edge against hand-computed values.
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  alu_op;
    logic [2:0]  sx_op;
    logic [2:0]  sx_op2;
    logic        mem_write;
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] unextended_data;
`ifdef DECODER_ILLEGAL_EN
    logic        illegal;
`endif

    int vectors     = 0;
    int comparisons = 0;
    int miscompares = 0;

    decoder #(
        .DATA_WIDTH (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instruction     (instruction),
        .f3              (f3),
        .f7              (f7),
        .alu_op          (alu_op),
        .sx_op           (sx_op),
        .sx_op2          (sx_op2),
        .mem_write       (mem_write),
        .reg_write       (reg_write),
        .mem_read        (mem_read),
        .rs1             (rs1),
        .rs2             (rs2),
        .rd              (rd),
        .unextended_data (unextended_data)
`ifdef DECODER_ILLEGAL_EN
        ,
        .illegal         (illegal)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkField(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        comparisons++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string name,
                               input logic [2:0] eF3, input logic [6:0] eF7,
                               input logic [2:0] eAlu, input logic [2:0] eSx,
                               input logic [2:0] eSx2, input logic eMw,
                               input logic eRw, input logic eMr,
                               input logic [4:0] eRs1, input logic [4:0] eRs2,
                               input logic [4:0] eRd, input logic [31:0] eData,
                               input logic eIll);
        vectors++;
        checkField({name, ".f3"},        32'(f3),        32'(eF3));
        checkField({name, ".f7"},        32'(f7),        32'(eF7));
        checkField({name, ".alu_op"},    32'(alu_op),    32'(eAlu));
        checkField({name, ".sx_op"},     32'(sx_op),     32'(eSx));
        checkField({name, ".sx_op2"},    32'(sx_op2),    32'(eSx2));
        checkField({name, ".mem_write"}, 32'(mem_write), 32'(eMw));
        checkField({name, ".reg_write"}, 32'(reg_write), 32'(eRw));
        checkField({name, ".mem_read"},  32'(mem_read),  32'(eMr));
        checkField({name, ".rs1"},       32'(rs1),       32'(eRs1));
        checkField({name, ".rs2"},       32'(rs2),       32'(eRs2));
        checkField({name, ".rd"},        32'(rd),        32'(eRd));
        checkField({name, ".data"},      unextended_data, eData);
`ifdef DECODER_ILLEGAL_EN
        checkField({name, ".illegal"},   32'(illegal),   32'(eIll));
`else
        if (eIll !== 1'b0 && alu_op !== 3'b111) begin
            miscompares++;
            $error("[TB] FAIL %s.invalid: observed alu_op 0x%0h expected 0x7", name, alu_op);
        end
`endif
    endtask

    task automatic applyStimulus(input logic [31:0] instr);
        @(negedge clk);
        instruction = instr;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence: reset, each instruction class, invalid words, mid-stream reset.
    initial begin
        rst_n       = 1'b0;
        instruction = 32'h000AAA83;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset", 3'd0, 7'h00, 3'd7, 3'd7, 3'd7, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h000AAA83);
        checkOutput("lw", 3'd2, 7'h00, 3'd0, 3'd0, 3'd1, 0, 1, 1, 5'd21, 5'd0, 5'd21, 32'h0, 0);

        applyStimulus(32'hFFFFFFFF);
        checkOutput("ones", 3'd0, 7'h00, 3'd7, 3'd7, 3'd7, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 1);

        applyStimulus(32'h00532423);
        checkOutput("sw", 3'd2, 7'h00, 3'd0, 3'd1, 3'd1, 1, 0, 0, 5'd6, 5'd5, 5'd0, 32'h8, 0);

        applyStimulus(32'h00000000);
        checkOutput("zero", 3'd0, 7'h00, 3'd7, 3'd7, 3'd7, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 1);

        applyStimulus(32'h402081B3);
        checkOutput("sub", 3'd0, 7'h20, 3'd1, 3'd7, 3'd7, 0, 1, 0, 5'd1, 5'd2, 5'd3, 32'h0, 0);

        applyStimulus(32'h002081B3);
        checkOutput("add", 3'd0, 7'h00, 3'd0, 3'd7, 3'd7, 0, 1, 0, 5'd1, 5'd2, 5'd3, 32'h0, 0);

        applyStimulus(32'h003170B3);
        checkOutput("and", 3'd7, 7'h00, 3'd2, 3'd7, 3'd7, 0, 1, 0, 5'd2, 5'd3, 5'd1, 32'h0, 0);

        applyStimulus(32'hFFF10093);
        checkOutput("addi", 3'd0, 7'h00, 3'd0, 3'd0, 3'd7, 0, 1, 0, 5'd2, 5'd0, 5'd1, 32'hFFF, 0);

        applyStimulus(32'h40335293);
        checkOutput("srai", 3'd5, 7'h20, 3'd6, 3'd5, 3'd7, 0, 1, 0, 5'd6, 5'd0, 5'd5, 32'h3, 0);

        applyStimulus(32'h00208463);
        checkOutput("beq", 3'd0, 7'h00, 3'd1, 3'd2, 3'd7, 0, 0, 0, 5'd1, 5'd2, 5'd0, 32'h8, 0);

        applyStimulus(32'h001010EF);
        checkOutput("jal", 3'd0, 7'h00, 3'd0, 3'd4, 3'd7, 0, 1, 0, 5'd0, 5'd0, 5'd1, 32'h1800, 0);

        applyStimulus(32'h004280E7);
        checkOutput("jalr", 3'd0, 7'h00, 3'd0, 3'd0, 3'd7, 0, 1, 0, 5'd5, 5'd0, 5'd1, 32'h4, 0);

        applyStimulus(32'h123453B7);
        checkOutput("lui", 3'd0, 7'h00, 3'd0, 3'd3, 3'd7, 0, 1, 0, 5'd0, 5'd0, 5'd7, 32'h12345, 0);

        applyStimulus(32'hFFFFF117);
        checkOutput("auipc", 3'd0, 7'h00, 3'd0, 3'd3, 3'd7, 0, 1, 0, 5'd0, 5'd0, 5'd2, 32'hFFFFF, 0);

        applyStimulus(32'hFFF1C203);
        checkOutput("lbu", 3'd4, 7'h00, 3'd0, 3'd0, 3'd3, 0, 1, 1, 5'd3, 5'd0, 5'd4, 32'hFFF, 0);

        applyStimulus(32'h0001B203);
        checkOutput("loadF3Rsvd", 3'd0, 7'h00, 3'd7, 3'd7, 3'd7, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 1);

        applyStimulus(32'h00313023);
        checkOutput("storeF3Rsvd", 3'd0, 7'h00, 3'd7, 3'd7, 3'd7, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 1);

        applyStimulus(32'h002081B3);
        checkOutput("addPreRst", 3'd0, 7'h00, 3'd0, 3'd7, 3'd7, 0, 1, 0, 5'd1, 5'd2, 5'd3, 32'h0, 0);

        @(negedge clk);
        instruction = 32'h000AAA83;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstAsync", 3'd0, 7'h00, 3'd7, 3'd7, 3'd7, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0);
        @(posedge clk);
        #1;
        checkOutput("rstHeld", 3'd0, 7'h00, 3'd7, 3'd7, 3'd7, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstReleased", 3'd0, 7'h00, 3'd7, 3'd7, 3'd7, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0);
        @(posedge clk);
        #1;
        checkOutput("lwAfterRst", 3'd2, 7'h00, 3'd0, 3'd0, 3'd1, 0, 1, 1, 5'd21, 5'd0, 5'd21, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
